// File: rtl/gray_sched_pkg.sv
// Shared types and helpers for the Gray-counter run arbiter.
package gray_sched_pkg;

  typedef enum logic [0:0] {IDLE, RUN} state_e;

  localparam int unsigned MaxReq = 8;
  localparam int unsigned IdxW   = 3;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Lowest set request strictly above ptr, else lowest set request overall.
  function automatic logic [IdxW-1:0] rr_pick(input logic [MaxReq-1:0] req,
                                               input logic [IdxW-1:0]   ptr);
    logic [MaxReq-1:0] hi;
    logic [IdxW-1:0]   idx;
    logic              found;
    hi    = req & (8'hfe << ptr);
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < MaxReq; i++) begin
      if (!found && hi[i]) begin
        idx   = IdxW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < MaxReq; i++) begin
      if (!found && req[i]) begin
        idx   = IdxW'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/gray_counter.sv
// Binary timebase counter with synchronous clear/enable and Gray-coded output.
module gray_counter
  import gray_sched_pkg::*;
#(
  parameter int unsigned CBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CBITS-1:0] cnt,
  output logic [CBITS-1:0] gray_c
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CBITS'(1);
    end
  end

  assign gray_c = CBITS'(bin2gray(32'(cnt)));

endmodule

// File: rtl/gray_run_arbiter.sv
// Round-robin owner selection for a shared Gray timebase; one run per grant,
// terminated by done (run length reached) or abort (owner dropped req).
module gray_run_arbiter
  import gray_sched_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CBITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CBITS-1:0] len,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [CBITS-1:0]      gray_c,
  output logic                  done,
  output logic                  abort
);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d, ptr_q, ptr_d, win;
  logic [CBITS-1:0]  last_q, last_d, win_len, cnt;
  logic [MaxReq-1:0] req_ext;
  logic              clr, en;

  assign req_ext = MaxReq'(req);
  assign win     = rr_pick(req_ext, ptr_q);
  assign busy    = (state_q == RUN);

  always_comb begin
    win_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IdxW'(i)) win_len = len[i*CBITS +: CBITS];
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = busy && (owner_q == IdxW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    done    = 1'b0;
    abort   = 1'b0;
    clr     = 1'b0;
    en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Counter is pinned at zero while idle.
        clr = 1'b1;
        if (|req) begin
          owner_d = win;
          last_d  = win_len - CBITS'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        en = 1'b1;
        if (!req_ext[owner_q]) begin
          abort   = 1'b1;
          clr     = 1'b1;
          ptr_d   = owner_q;
          state_d = IDLE;
        end else if (cnt == last_q) begin
          done    = 1'b1;
          clr     = 1'b1;
          ptr_d   = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= IdxW'(NREQ - 1);
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
    end
  end

  gray_counter #(
    .CBITS(CBITS)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .en    (en),
    .cnt   (cnt),
    .gray_c(gray_c)
  );

endmodule

// File: tb/tb_gray_run_arbiter.sv
// Directed bench for gray_run_arbiter (NREQ=4, CBITS=8).
module tb_gray_run_arbiter;

  logic        clk, rst;
  logic [3:0]  req;
  logic [31:0] len;
  logic [3:0]  grant;
  logic        busy, done, abort;
  logic [7:0]  gray_c;
  int          checks = 0;
  int          failures = 0;

  gray_run_arbiter #(
    .NREQ (4),
    .CBITS(8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .len   (len),
    .grant (grant),
    .busy  (busy),
    .gray_c(gray_c),
    .done  (done),
    .abort (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    len = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    len = '0;
    #1;
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || gray_c !== 8'h00 || done !== 1'b0 ||
        abort !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got grant=%b busy=%b gray=%h done=%b abort=%b exp all 0",
               grant, busy, gray_c, done, abort);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b grant=%b exp 0/0000", busy, grant);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_g [5];
    exp_g = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06};
    do_reset();
    len[7:0] = 8'd5;
    req = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (grant !== 4'b0001 || busy !== 1'b1) begin
        failures++;
        $display("FAIL single_grant k=%0d got grant=%b busy=%b exp 0001/1", k, grant, busy);
      end
      checks++;
      if (gray_c !== exp_g[k]) begin
        failures++;
        $display("FAIL single_gray k=%0d got %h exp %h", k, gray_c, exp_g[k]);
      end
      checks++;
      if (done !== (k == 4) || abort !== 1'b0) begin
        failures++;
        $display("FAIL single_done k=%0d got done=%b abort=%b exp done=%b abort=0",
                 k, done, abort, (k == 4));
      end
    end
    @(posedge clk);
    #1 req = 4'b0000;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0000 || done !== 1'b0) begin
      failures++;
      $display("FAIL single_end got busy=%b grant=%b done=%b exp 0/0000/0", busy, grant, done);
    end
  endtask

  task automatic test_round_robin();
    int         dones;
    logic [3:0] exp_gr;
    logic [7:0] exp_gy;
    dones = 0;
    do_reset();
    len = {8'd2, 8'd2, 8'd2, 8'd2};
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        exp_gr = (c < 2) ? 4'(1 << (r % 4)) : 4'b0000;
        exp_gy = (c == 1) ? 8'h01 : 8'h00;
        checks++;
        if (grant !== exp_gr || done !== (c == 1) || gray_c !== exp_gy) begin
          failures++;
          $display("FAIL rr_cycle r=%0d c=%0d got grant=%b done=%b gray=%h exp %b/%b/%h",
                   r, c, grant, done, gray_c, exp_gr, (c == 1), exp_gy);
        end
        if (done === 1'b1) dones++;
      end
    end
    req = 4'b0000;
    checks++;
    if (dones != 5) begin
      failures++;
      $display("FAIL rr_done_count got %0d exp 5", dones);
    end
  endtask

  task automatic test_len_zero();
    int         bad;
    logic [7:0] prev;
    bad  = 0;
    prev = '0;
    do_reset();
    len[15:8] = 8'd0;
    req = 4'b0010;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (grant !== 4'b0010 || gray_c !== 8'(k ^ (k >> 1)) || done !== (k == 255)) bad++;
      if (k > 0 && $countones(gray_c ^ prev) != 1) bad++;
      prev = gray_c;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL len0_sequence got %0d bad cycles exp 0", bad);
    end
    checks++;
    if (gray_c !== 8'h80 || done !== 1'b1) begin
      failures++;
      $display("FAIL len0_last got gray=%h done=%b exp 80/1", gray_c, done);
    end
    @(posedge clk);
    #1 req = 4'b0000;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL len0_end got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_abort();
    do_reset();
    len[15:8] = 8'd10;
    req = 4'b0010;
    repeat (2) @(negedge clk);
    checks++;
    if (grant !== 4'b0010 || abort !== 1'b0) begin
      failures++;
      $display("FAIL abort_pre got grant=%b abort=%b exp 0010/0", grant, abort);
    end
    @(negedge clk);
    req = 4'b1001;
    #1;
    checks++;
    if (abort !== 1'b1 || done !== 1'b0 || grant !== 4'b0010) begin
      failures++;
      $display("FAIL abort_pulse got abort=%b done=%b grant=%b exp 1/0/0010",
               abort, done, grant);
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || abort !== 1'b0 || gray_c !== 8'h00) begin
      failures++;
      $display("FAIL abort_idle got grant=%b busy=%b abort=%b gray=%h exp 0000/0/0/00",
               grant, busy, abort, gray_c);
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b1000) begin
      failures++;
      $display("FAIL abort_next_owner got %b exp 1000", grant);
    end
    req = 4'b0000;
  endtask

  task automatic test_async_reset();
    do_reset();
    len[23:16] = 8'd4;
    req = 4'b0100;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || grant !== 4'b0100 || gray_c !== 8'h01) begin
      failures++;
      $display("FAIL async_pre got busy=%b grant=%b gray=%h exp 1/0100/01", busy, grant, gray_c);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || gray_c !== 8'h00 || done !== 1'b0 ||
        abort !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got grant=%b busy=%b gray=%h done=%b abort=%b exp all 0",
               grant, busy, gray_c, done, abort);
    end
    req = 4'b0101;
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL async_first_winner got %b exp 0001", grant);
    end
    req = 4'b0000;
  endtask

  task automatic test_len_change();
    do_reset();
    len[7:0] = 8'd3;
    req = 4'b0001;
    @(negedge clk);
    len[7:0] = 8'd9;
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (grant !== 4'b0001 || done !== (k == 2)) begin
        failures++;
        $display("FAIL lenchg_first k=%0d got grant=%b done=%b exp 0001/%b",
                 k, grant, done, (k == 2));
      end
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin
      failures++;
      $display("FAIL lenchg_gap got %b exp 0000", grant);
    end
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      checks++;
      if (grant !== 4'b0001 || done !== (k == 8)) begin
        failures++;
        $display("FAIL lenchg_second k=%0d got grant=%b done=%b exp 0001/%b",
                 k, grant, done, (k == 8));
      end
    end
    @(posedge clk);
    #1 req = 4'b0000;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL lenchg_end got busy=%b exp 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_len_zero();
    test_abort();
    test_async_reset();
    test_len_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
